// File: rtl/machine_mode_types_1_11_pkg.sv
// ---------------------------------------------------------------------------
// machine_mode_types_1_11_pkg
// Shared types and constants for the machine-mode trap controller:
//   - exception cause codes (mcause values with bit 31 clear)
//   - interrupt cause enum (mcause values with bit 31 set)
//   - trap sequencer state enum
//   - helpers for the extension-cause port width and the mtval selection
// ---------------------------------------------------------------------------
package machine_mode_types_1_11_pkg;

   // Synchronous exception codes
   localparam logic [4:0] EXC_MAL_INSN   = 5'd0;
   localparam logic [4:0] EXC_FAULT_INSN = 5'd1;
   localparam logic [4:0] EXC_ILLEGAL    = 5'd2;
   localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
   localparam logic [4:0] EXC_MAL_L      = 5'd4;
   localparam logic [4:0] EXC_FAULT_L    = 5'd5;
   localparam logic [4:0] EXC_MAL_S      = 5'd6;
   localparam logic [4:0] EXC_FAULT_S    = 5'd7;
   localparam logic [4:0] EXC_ENV_M      = 5'd11;

   // Machine-level interrupt codes
   typedef enum logic [4:0] {
      IRQ_SOFT  = 5'd3,
      IRQ_TIMER = 5'd7,
      IRQ_EXT   = 5'd11
   } irq_cause_e;

   // Trap / return sequencer states
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_COMMIT     = 3'd2,
      ST_REDIRECT   = 3'd3,
      ST_RET_DRAIN  = 3'd4,
      ST_RET_COMMIT = 3'd5
   } trap_state_e;

   // Width of the extension index; a single extension still needs one bit
   function automatic int rmgmt_cause_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   // Address/instruction-related exceptions (0,1,2,4,5,6,7) report badaddr
   // in mtval; breakpoint, ecall, extensions and interrupts report zero.
   function automatic logic mtval_from_badaddr(input logic is_int,
                                               input logic [30:0] cause);
      logic w_hit;
      w_hit = 1'b0;
      if (!is_int && (cause < 31'd8) && (cause != 31'd3)) begin
         w_hit = 1'b1;
      end else begin
         w_hit = 1'b0;
      end
      return w_hit;
   endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// ---------------------------------------------------------------------------
// prv_trap_prio
// Combinational priority encoder for trap events.
// Ports:
//   exception flags (fault_insn .. env_m, ex_rmgmt + ex_rmgmt_cause) in
//   interrupt pending lines and enables (timer/soft/ext, mstatus_mie, mie_*) in
//   valid  out  a trap-worthy event is present
//   is_int out  the winning event is an interrupt
//   cause  out  31-bit mcause code of the winning event
// Exceptions always beat interrupts; mret is handled by the sequencer.
// ---------------------------------------------------------------------------
module prv_trap_prio
   import machine_mode_types_1_11_pkg::*;
#(
   parameter int NUM_EXTENSIONS   = 1,
   parameter int RMGMT_CAUSE_BASE = 24
) (
   input  logic                                     fault_insn,
   input  logic                                     mal_insn,
   input  logic                                     illegal_insn,
   input  logic                                     fault_l,
   input  logic                                     mal_l,
   input  logic                                     fault_s,
   input  logic                                     mal_s,
   input  logic                                     breakpoint,
   input  logic                                     env_m,
   input  logic                                     ex_rmgmt,
   input  logic [rmgmt_cause_w(NUM_EXTENSIONS)-1:0] ex_rmgmt_cause,
   input  logic                                     timer_int,
   input  logic                                     soft_int,
   input  logic                                     ext_int,
   input  logic                                     mstatus_mie,
   input  logic                                     mie_mtie,
   input  logic                                     mie_msie,
   input  logic                                     mie_meie,
   output logic                                     valid,
   output logic                                     is_int,
   output logic [30:0]                              cause
);

   logic w_ext_en;
   logic w_soft_en;
   logic w_timer_en;

   assign w_ext_en   = mstatus_mie & mie_meie & ext_int;
   assign w_soft_en  = mstatus_mie & mie_msie & soft_int;
   assign w_timer_en = mstatus_mie & mie_mtie & timer_int;

   // Fixed-priority selection: exceptions in architectural order, then interrupts
   always_comb begin
      valid  = 1'b1;
      is_int = 1'b0;
      cause  = 31'd0;
      if (breakpoint) begin
         cause = {26'd0, EXC_BREAKPOINT};
      end else if (fault_insn) begin
         cause = {26'd0, EXC_FAULT_INSN};
      end else if (mal_insn) begin
         cause = {26'd0, EXC_MAL_INSN};
      end else if (illegal_insn) begin
         cause = {26'd0, EXC_ILLEGAL};
      end else if (env_m) begin
         cause = {26'd0, EXC_ENV_M};
      end else if (mal_s) begin
         cause = {26'd0, EXC_MAL_S};
      end else if (mal_l) begin
         cause = {26'd0, EXC_MAL_L};
      end else if (fault_s) begin
         cause = {26'd0, EXC_FAULT_S};
      end else if (fault_l) begin
         cause = {26'd0, EXC_FAULT_L};
      end else if (ex_rmgmt) begin
         cause = 31'(RMGMT_CAUSE_BASE) + 31'(ex_rmgmt_cause);
      end else if (w_ext_en) begin
         is_int = 1'b1;
         cause  = {26'd0, IRQ_EXT};
      end else if (w_soft_en) begin
         is_int = 1'b1;
         cause  = {26'd0, IRQ_SOFT};
      end else if (w_timer_en) begin
         is_int = 1'b1;
         cause  = {26'd0, IRQ_TIMER};
      end else begin
         valid  = 1'b0;
      end
   end

endmodule

// File: rtl/prv_trap_ctrl.sv
// ---------------------------------------------------------------------------
// prv_trap_ctrl
// Trap / mret sequencer on the privilege side of the pipeline handshake.
// An event accepted in IDLE is latched, the pipeline is drained, the CSR
// file is written (trap) or mstatus is restored (mret), and fetch is
// redirected through insert_pc/priv_pc.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   exception flags, ex_rmgmt(_cause), ret, pipe_clear   hazard unit inputs
//   epc, badaddr             PC / faulting address of the trapping insn
//   timer/soft/ext_int, mstatus_mie, mie_*   interrupt lines and enables
//   mtvec, mepc_r            current CSR values
//   insert_pc, priv_pc       fetch redirect
//   intr                     sequence in progress (pipeline flush/stall)
//   csr_trap_we, csr_ret_we  CSR update strobes
//   mepc/mcause/mtval_wdata  values written with csr_trap_we
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module prv_trap_ctrl
   import machine_mode_types_1_11_pkg::*;
#(
   parameter int NUM_EXTENSIONS   = 1,
   parameter int RMGMT_CAUSE_BASE = 24
) (
   input  logic                                     CLK,
   input  logic                                     RST,
   input  logic                                     fault_insn,
   input  logic                                     mal_insn,
   input  logic                                     illegal_insn,
   input  logic                                     fault_l,
   input  logic                                     mal_l,
   input  logic                                     fault_s,
   input  logic                                     mal_s,
   input  logic                                     breakpoint,
   input  logic                                     env_m,
   input  logic                                     ex_rmgmt,
   input  logic [rmgmt_cause_w(NUM_EXTENSIONS)-1:0] ex_rmgmt_cause,
   input  logic                                     ret,
   input  logic                                     pipe_clear,
   input  logic [31:0]                              epc,
   input  logic [31:0]                              badaddr,
   input  logic                                     timer_int,
   input  logic                                     soft_int,
   input  logic                                     ext_int,
   input  logic                                     mstatus_mie,
   input  logic                                     mie_mtie,
   input  logic                                     mie_msie,
   input  logic                                     mie_meie,
   input  logic [31:0]                              mtvec,
   input  logic [31:0]                              mepc_r,
   output logic                                     insert_pc,
   output logic [31:0]                              priv_pc,
   output logic                                     intr,
   output logic                                     csr_trap_we,
   output logic                                     csr_ret_we,
   output logic [31:0]                              mepc_wdata,
   output logic [31:0]                              mcause_wdata,
   output logic [31:0]                              mtval_wdata
);

   logic        w_valid;
   logic        w_is_int;
   logic [30:0] w_cause;

   trap_state_e r_state;
   trap_state_e w_next;
   logic        w_latch;
   logic [31:0] w_next_pc;
   logic [31:0] w_base;

   logic        r_is_int;
   logic [30:0] r_cause;
   logic [31:0] r_epc;
   logic [31:0] r_mtval;
   logic        r_insert_pc;
   logic [31:0] r_priv_pc;
   logic        r_intr;
   logic        r_trap_we;
   logic        r_ret_we;

   prv_trap_prio #(
      .NUM_EXTENSIONS   (NUM_EXTENSIONS),
      .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
   ) u_prio (
      .fault_insn     (fault_insn),
      .mal_insn       (mal_insn),
      .illegal_insn   (illegal_insn),
      .fault_l        (fault_l),
      .mal_l          (mal_l),
      .fault_s        (fault_s),
      .mal_s          (mal_s),
      .breakpoint     (breakpoint),
      .env_m          (env_m),
      .ex_rmgmt       (ex_rmgmt),
      .ex_rmgmt_cause (ex_rmgmt_cause),
      .timer_int      (timer_int),
      .soft_int       (soft_int),
      .ext_int        (ext_int),
      .mstatus_mie    (mstatus_mie),
      .mie_mtie       (mie_mtie),
      .mie_msie       (mie_msie),
      .mie_meie       (mie_meie),
      .valid          (w_valid),
      .is_int         (w_is_int),
      .cause          (w_cause)
   );

   assign w_base = {mtvec[31:2], 2'b00};

   // Next-state logic; events are only looked at in IDLE, so the latched
   // event is frozen for the rest of the sequence.
   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_next  = ST_DRAIN;
               w_latch = 1'b1;
            end else if (ret) begin
               w_next  = ST_RET_DRAIN;
            end else begin
               w_next  = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (pipe_clear) begin
               w_next = ST_COMMIT;
            end else begin
               w_next = ST_DRAIN;
            end
         end
         ST_COMMIT:   w_next = ST_REDIRECT;
         ST_REDIRECT: w_next = ST_IDLE;
         ST_RET_DRAIN: begin
            if (pipe_clear) begin
               w_next = ST_RET_COMMIT;
            end else begin
               w_next = ST_RET_DRAIN;
            end
         end
         ST_RET_COMMIT: w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
   end

   // Redirect target for the coming cycle; vectored mode only applies to interrupts
   always_comb begin
      w_next_pc = 32'd0;
      case (w_next)
         ST_REDIRECT: begin
            if ((mtvec[1:0] == 2'b01) && r_is_int) begin
               w_next_pc = w_base + {25'd0, r_cause[4:0], 2'b00};
            end else begin
               w_next_pc = w_base;
            end
         end
         ST_RET_COMMIT: w_next_pc = mepc_r;
         default:       w_next_pc = 32'd0;
      endcase
   end

   // State, registered outputs and event latches
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_is_int    <= 1'b0;
         r_cause     <= 31'd0;
         r_epc       <= 32'd0;
         r_mtval     <= 32'd0;
         r_insert_pc <= 1'b0;
         r_priv_pc   <= 32'd0;
         r_intr      <= 1'b0;
         r_trap_we   <= 1'b0;
         r_ret_we    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_intr      <= (w_next != ST_IDLE);
         r_trap_we   <= (w_next == ST_COMMIT);
         r_ret_we    <= (w_next == ST_RET_COMMIT);
         r_insert_pc <= (w_next == ST_REDIRECT) || (w_next == ST_RET_COMMIT);
         r_priv_pc   <= w_next_pc;
         if (w_latch) begin
            r_is_int <= w_is_int;
            r_cause  <= w_cause;
            r_epc    <= epc;
            r_mtval  <= mtval_from_badaddr(w_is_int, w_cause) ? badaddr : 32'd0;
         end else begin
            r_is_int <= r_is_int;
            r_cause  <= r_cause;
            r_epc    <= r_epc;
            r_mtval  <= r_mtval;
         end
      end
   end

   assign insert_pc    = r_insert_pc;
   assign priv_pc      = r_priv_pc;
   assign intr         = r_intr;
   assign csr_trap_we  = r_trap_we;
   assign csr_ret_we   = r_ret_we;
   assign mepc_wdata   = {r_epc[31:2], 2'b00};
   assign mcause_wdata = {r_is_int, r_cause};
   assign mtval_wdata  = r_mtval;

endmodule
